rd_slave_arbiter: RTL and testbench
===================================

Name: rd_slave_arbiter

Overview:
- One instance per slave on the read path.
- Decodes the AR requests of two masters against this slave's address window and picks one master by round-robin.
- Forwards the granted master's AR channel to the slave and holds the grant until the last read beat completes.
- Drives the per-slave mas_sel code that the downstream read-return mux (rd_sl_return) uses to route ARREADY and the R channel back to the granted master.

Parameters:
- ADDR_W, 32, address width.
- ID_W, 64, ARID width; matches the return-path RID width.
- SLV_BASE, 32'h0000_0000, slave window base address.
- SLV_MASK, 32'hF000_0000, decode mask. A master hits this slave when (ARADDR & SLV_MASK) == SLV_BASE.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- m1_ARVALID, m2_ARVALID  in  1  master AR valid.
- m1_ARADDR, m2_ARADDR  in  ADDR_W  master AR address.
- m1_ARID, m2_ARID  in  ID_W  master AR ID.
- m1_ARLEN, m2_ARLEN  in  8  burst length minus 1.
- m1_ARSIZE, m2_ARSIZE  in  3  beat size.
- m1_ARBURST, m2_ARBURST  in  2  burst type.
- m1_RREADY, m2_RREADY  in  1  master R ready.
- s_ARREADY  in  1  slave AR ready.
- s_RVALID  in  1  slave R valid.
- s_RLAST  in  1  slave R last.
- s_ARVALID  out  1  AR valid to slave.
- s_ARADDR, s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST  out  as inputs  AR payload to slave.
- s_RREADY  out  1  R ready to slave.
- mas_sel  out  2  2'b00 idle, 2'b01 master 1, 2'b10 master 2. 2'b11 is never driven.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, mas_sel = 2'b00.
  - s_ARVALID = 0, s_RREADY = 0, busy = 0.
  - s_AR payload = 0.
  - rr_last = master 2, so master 1 wins the first tie.
- Request: req_k = mk_ARVALID && ((mk_ARADDR & SLV_MASK) == SLV_BASE).
- States:
  - IDLE:
    - No request: stay in IDLE.
    - Only req1: grant master 1. Only req2: grant master 2.
    - Both: grant the master that is not rr_last.
    - On grant: register mas_sel, update rr_last, go to ADDR.
    - Outputs in IDLE: s_ARVALID = 0, s_RREADY = 0, mas_sel = 00.
  - ADDR:
    - s_ARVALID and s_AR payload are a combinational pass-through of the granted master's AR signals.
    - The master's ARREADY is returned by rd_sl_return from s_ARREADY via mas_sel; this block generates no master ARREADY.
    - s_ARVALID && s_ARREADY: go to DATA.
    - Granted master drops ARVALID (protocol violation): s_ARVALID follows it to 0, grant is held, stay in ADDR.
  - DATA:
    - s_ARVALID = 0; payload is held at the last forwarded values.
    - s_RREADY = granted master's RREADY.
    - s_RVALID && s_RREADY && s_RLAST: go to IDLE and drop mas_sel to 00 on the next edge.
    - Non-last beats: stay in DATA.
- Latency:
  - Request to s_ARVALID is 1 cycle (grant registered in IDLE).
  - At least one IDLE cycle occurs between consecutive bursts, even if a new request is present on the last-beat cycle.
- Stability: mas_sel changes only on IDLE->ADDR and DATA->IDLE transitions and is constant from ADDR through the final beat.
- Request for another slave: a master whose address misses the window is ignored entirely.
- Reset mid-burst: immediate return to reset values; the in-flight burst is abandoned.

Optional Feature:
- Macro: RD_ARB_BEAT_CHECK_EN.
- Defined:
  - Latch the granted ARLEN at the AR handshake.
  - An 8-bit beat counter increments on each s_RVALID && s_RREADY.
  - Release the grant when the counter equals the latched ARLEN, or on s_RLAST, whichever comes first.
  - Output port beat_err (1 bit, reset 0) pulses for one cycle when s_RLAST and the counter == ARLEN disagree on the releasing beat.
- Not defined: port absent, no counter; release on s_RLAST only.

Test Plan:
- Reset then m1 requests ARADDR=0x0000_0010, ARID=1, ARLEN=3 -> mas_sel=01 and s_ARVALID=1 one cycle later; s_ARADDR=0x10. After 4 beats with RLAST on the 4th, mas_sel=00 the next cycle.
- m1 and m2 both request in the same cycle, repeated twice -> grants are m1 then m2. m2's s_ARVALID appears only after m1's last beat plus one IDLE cycle.
- m2 requests ARADDR=0x1000_0000 (outside the window) -> stays IDLE, mas_sel=00, s_ARVALID=0.
- In DATA, m1_RREADY=0 for 3 cycles with s_RVALID=1 -> s_RREADY=0 and state holds. RREADY=1 with RLAST=1 -> release.
- Assert i_rst mid-DATA -> all outputs 0 asynchronously. Next m1 and m2 tie after reset -> m1 wins.
- RD_ARB_BEAT_CHECK_EN defined, ARLEN=1, slave asserts RLAST on the 3rd beat -> release after the 2nd beat, beat_err=1 for one cycle.

Source files
------------

// File: rtl/rd_slave_arbiter_if.sv
// AR/R signal bundle between two read masters, one slave and its rd_slave_arbiter.
interface rd_slave_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int ID_W   = 64
);
   logic              m1_ARVALID, m2_ARVALID;
   logic [ADDR_W-1:0] m1_ARADDR,  m2_ARADDR;
   logic [ID_W-1:0]   m1_ARID,    m2_ARID;
   logic [7:0]        m1_ARLEN,   m2_ARLEN;
   logic [2:0]        m1_ARSIZE,  m2_ARSIZE;
   logic [1:0]        m1_ARBURST, m2_ARBURST;
   logic              m1_RREADY,  m2_RREADY;
   logic              s_ARREADY, s_RVALID, s_RLAST;
   logic              s_ARVALID;
   logic [ADDR_W-1:0] s_ARADDR;
   logic [ID_W-1:0]   s_ARID;
   logic [7:0]        s_ARLEN;
   logic [2:0]        s_ARSIZE;
   logic [1:0]        s_ARBURST;
   logic              s_RREADY;
   logic [1:0]        mas_sel;
   logic              busy;

   modport slave (
      input  m1_ARVALID, m2_ARVALID, m1_ARADDR, m2_ARADDR, m1_ARID, m2_ARID,
             m1_ARLEN, m2_ARLEN, m1_ARSIZE, m2_ARSIZE, m1_ARBURST, m2_ARBURST,
             m1_RREADY, m2_RREADY, s_ARREADY, s_RVALID, s_RLAST,
      output s_ARVALID, s_ARADDR, s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST,
             s_RREADY, mas_sel, busy
   );

   modport master (
      output m1_ARVALID, m2_ARVALID, m1_ARADDR, m2_ARADDR, m1_ARID, m2_ARID,
             m1_ARLEN, m2_ARLEN, m1_ARSIZE, m2_ARSIZE, m1_ARBURST, m2_ARBURST,
             m1_RREADY, m2_RREADY, s_ARREADY, s_RVALID, s_RLAST,
      input  s_ARVALID, s_ARADDR, s_ARID, s_ARLEN, s_ARSIZE, s_ARBURST,
             s_RREADY, mas_sel, busy
   );
endinterface

// File: rtl/rd_slave_arbiter.sv
// Per-slave read arbiter: round-robin grant between two masters, held from AR through last R beat.
// RD_ARB_BEAT_CHECK_EN adds an ARLEN beat counter that can end the burst early and flags RLAST disagreement.
module rd_slave_arbiter #(
   parameter int              ADDR_W   = 32,
   parameter int              ID_W     = 64,
   parameter logic [ADDR_W-1:0] SLV_BASE = 32'h0000_0000,
   parameter logic [ADDR_W-1:0] SLV_MASK = 32'hF000_0000
) (
   input  logic i_clk,
   input  logic i_rst,
`ifdef RD_ARB_BEAT_CHECK_EN
   output logic beat_err,
`endif
   rd_slave_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t            state, state_nxt;
   logic [1:0]        sel, sel_nxt;
   logic              rr_last, rr_nxt;   // 1: master 2 was granted last
   logic [ADDR_W-1:0] addr_q;
   logic [ID_W-1:0]   id_q;
   logic [7:0]        len_q;
   logic [2:0]        size_q;
   logic [1:0]        burst_q;

   logic              req1, req2, g2;
   logic              g_vld, g_rready;
   logic [ADDR_W-1:0] g_addr;
   logic [ID_W-1:0]   g_id;
   logic [7:0]        g_len;
   logic [2:0]        g_size;
   logic [1:0]        g_burst;
   logic              rready, beat, rel;

   assign req1 = bus.m1_ARVALID && ((bus.m1_ARADDR & SLV_MASK) == SLV_BASE);
   assign req2 = bus.m2_ARVALID && ((bus.m2_ARADDR & SLV_MASK) == SLV_BASE);

   assign g2       = (sel == 2'b10);
   assign g_vld    = g2 ? bus.m2_ARVALID : bus.m1_ARVALID;
   assign g_addr   = g2 ? bus.m2_ARADDR  : bus.m1_ARADDR;
   assign g_id     = g2 ? bus.m2_ARID    : bus.m1_ARID;
   assign g_len    = g2 ? bus.m2_ARLEN   : bus.m1_ARLEN;
   assign g_size   = g2 ? bus.m2_ARSIZE  : bus.m1_ARSIZE;
   assign g_burst  = g2 ? bus.m2_ARBURST : bus.m1_ARBURST;
   assign g_rready = g2 ? bus.m2_RREADY  : bus.m1_RREADY;

   assign rready = (state == DATA) && g_rready;
   assign beat   = (state == DATA) && bus.s_RVALID && rready;

`ifdef RD_ARB_BEAT_CHECK_EN
   logic [7:0] beat_cnt;
   logic       cnt_hit;

   // len_q holds the ARLEN captured at the AR handshake for the whole DATA phase
   assign cnt_hit = (beat_cnt == len_q);
   assign rel     = beat && (bus.s_RLAST || cnt_hit);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         beat_cnt <= 8'd0;
         beat_err <= 1'b0;
      end else begin
         if (state == ADDR)
            beat_cnt <= 8'd0;
         else if (beat)
            beat_cnt <= beat_cnt + 8'd1;
         beat_err <= rel && (bus.s_RLAST != cnt_hit);
      end
   end
`else
   assign rel = beat && bus.s_RLAST;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         sel     <= 2'b00;
         rr_last <= 1'b1;
         addr_q  <= '0;
         id_q    <= '0;
         len_q   <= '0;
         size_q  <= '0;
         burst_q <= '0;
      end else begin
         state   <= state_nxt;
         sel     <= sel_nxt;
         rr_last <= rr_nxt;
         if (state == ADDR) begin
            addr_q  <= g_addr;
            id_q    <= g_id;
            len_q   <= g_len;
            size_q  <= g_size;
            burst_q <= g_burst;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      sel_nxt       = sel;
      rr_nxt        = rr_last;
      bus.s_ARVALID = 1'b0;
      bus.s_ARADDR  = addr_q;
      bus.s_ARID    = id_q;
      bus.s_ARLEN   = len_q;
      bus.s_ARSIZE  = size_q;
      bus.s_ARBURST = burst_q;
      case (state)
         IDLE: begin
            if (req1 && (!req2 || rr_last)) begin
               sel_nxt   = 2'b01;
               rr_nxt    = 1'b0;
               state_nxt = ADDR;
            end else if (req2) begin
               sel_nxt   = 2'b10;
               rr_nxt    = 1'b1;
               state_nxt = ADDR;
            end
         end
         ADDR: begin
            bus.s_ARVALID = g_vld;
            bus.s_ARADDR  = g_addr;
            bus.s_ARID    = g_id;
            bus.s_ARLEN   = g_len;
            bus.s_ARSIZE  = g_size;
            bus.s_ARBURST = g_burst;
            if (g_vld && bus.s_ARREADY)
               state_nxt = DATA;
         end
         DATA: begin
            if (rel) begin
               state_nxt = IDLE;
               sel_nxt   = 2'b00;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.s_RREADY = rready;
   assign bus.mas_sel  = sel;
   assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_rd_slave_arbiter.sv
// Bench for rd_slave_arbiter: directed table, hand corner sequences, randomized bursts vs reference model.
module tb_rd_slave_arbiter;
   localparam int          ADDR_W = 32;
   localparam int          ID_W   = 64;
   localparam logic [31:0] BASE   = 32'h0000_0000;
   localparam logic [31:0] MASK   = 32'hF000_0000;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   last_win = 2;
   logic [31:0] a_m   [1:2];
   logic [63:0] id_m  [1:2];
   logic [7:0]  len_m [1:2];

   always #5 i_clk = ~i_clk;

   rd_slave_arbiter_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();
`ifdef RD_ARB_BEAT_CHECK_EN
   logic beat_err;
`endif

   rd_slave_arbiter #(.ADDR_W(ADDR_W), .ID_W(ID_W), .SLV_BASE(BASE), .SLV_MASK(MASK)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
`ifdef RD_ARB_BEAT_CHECK_EN
      .beat_err(beat_err),
`endif
      .bus(bus)
   );

   typedef struct {
      logic        v1;
      logic [31:0] a1;
      logic        v2;
      logic [31:0] a2;
      int          exp_sel;
   } vec_t;
   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      bus.m1_ARVALID = 0; bus.m2_ARVALID = 0;
      bus.m1_ARADDR = 0;  bus.m2_ARADDR = 0;
      bus.m1_ARID = 0;    bus.m2_ARID = 0;
      bus.m1_ARLEN = 0;   bus.m2_ARLEN = 0;
      bus.m1_ARSIZE = 0;  bus.m2_ARSIZE = 0;
      bus.m1_ARBURST = 0; bus.m2_ARBURST = 0;
      bus.m1_RREADY = 0;  bus.m2_RREADY = 0;
      bus.s_ARREADY = 0;  bus.s_RVALID = 0; bus.s_RLAST = 0;
   endtask

   task automatic drive_req(input logic v1, input logic [31:0] a1, input logic [7:0] l1,
                            input logic v2, input logic [31:0] a2, input logic [7:0] l2);
      a_m[1] = a1; id_m[1] = {$urandom, $urandom}; len_m[1] = l1;
      a_m[2] = a2; id_m[2] = {$urandom, $urandom}; len_m[2] = l2;
      bus.m1_ARVALID = v1; bus.m1_ARADDR = a1; bus.m1_ARID = id_m[1]; bus.m1_ARLEN = l1;
      bus.m2_ARVALID = v2; bus.m2_ARADDR = a2; bus.m2_ARID = id_m[2]; bus.m2_ARLEN = l2;
      bus.m1_ARSIZE = 3'd2; bus.m2_ARSIZE = 3'd3;
      bus.m1_ARBURST = 2'b01; bus.m2_ARBURST = 2'b01;
   endtask

   task automatic check_grant(input int g, input string tag);
      chk({tag, "_sel"}, 64'(bus.mas_sel), 64'(g));
      chk({tag, "_arvalid"}, 64'(bus.s_ARVALID), 64'(g != 0));
      chk({tag, "_busy"}, 64'(bus.busy), 64'(g != 0));
      if (g != 0) begin
         chk({tag, "_araddr"}, 64'(bus.s_ARADDR), 64'(a_m[g]));
         chk({tag, "_arid"}, bus.s_ARID, id_m[g]);
         chk({tag, "_arlen"}, 64'(bus.s_ARLEN), 64'(len_m[g]));
      end
   endtask

   // Entered at the negedge of the first ADDR cycle; returns at the negedge after release.
   task automatic do_burst(input int g, input int nbeats, input int ar_wait, input bit rnd);
      int done, cyc;
      bit rv, rr;
      for (int i = 0; i < ar_wait; i++) begin
         @(negedge i_clk);
         chk("addr_hold_vld", 64'(bus.s_ARVALID), 64'd1);
         chk("addr_hold_sel", 64'(bus.mas_sel), 64'(g));
      end
      bus.s_ARREADY = 1;
      @(negedge i_clk);
      bus.s_ARREADY = 0; bus.m1_ARVALID = 0; bus.m2_ARVALID = 0;
      chk("data_arvalid", 64'(bus.s_ARVALID), 64'd0);
      done = 0;
      cyc = 0;
      while (done < nbeats && cyc < 200) begin
         chk("data_sel", 64'(bus.mas_sel), 64'(g));
         rv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         rr = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.s_RVALID = rv;
         bus.s_RLAST  = rv && (done == nbeats - 1);
         bus.m1_RREADY = (g == 1) ? rr : 1'($urandom_range(0, 1));
         bus.m2_RREADY = (g == 2) ? rr : 1'($urandom_range(0, 1));
         #1;
         chk("rready_route", 64'(bus.s_RREADY), 64'(rr));
         if (rv && rr) done++;
         @(negedge i_clk);
         cyc++;
      end
      chk("beat_budget", 64'(done), 64'(nbeats));
      bus.s_RVALID = 0; bus.s_RLAST = 0; bus.m1_RREADY = 0; bus.m2_RREADY = 0;
      chk("release_sel", 64'(bus.mas_sel), 64'd0);
      chk("release_busy", 64'(bus.busy), 64'd0);
   endtask

   function automatic int model_grant(input logic v1, input logic [31:0] a1,
                                      input logic v2, input logic [31:0] a2);
      bit h1, h2;
      h1 = v1 && ((a1 & MASK) == BASE);
      h2 = v2 && ((a2 & MASK) == BASE);
      if (h1 && h2) return (last_win == 1) ? 2 : 1;
      if (h1) return 1;
      if (h2) return 2;
      return 0;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      logic        v1, v2;
      logic [31:0] a1, a2;
      int          exp;

      vecs[0] = '{1'b1, 32'h0000_0010, 1'b1, 32'h0000_0020, 2};
      vecs[1] = '{1'b1, 32'h0000_0030, 1'b1, 32'h0000_0040, 1};
      vecs[2] = '{1'b1, 32'h0000_0050, 1'b1, 32'h1000_0000, 1};
      vecs[3] = '{1'b1, 32'h2000_0000, 1'b0, 32'h0000_0060, 0};
      vecs[4] = '{1'b0, 32'h0000_0070, 1'b1, 32'h0FFF_FFF0, 2};
      vecs[5] = '{1'b1, 32'h0ABC_0000, 1'b1, 32'hF000_0000, 1};
      vecs[6] = '{1'b1, 32'h0000_0080, 1'b1, 32'h0000_0090, 2};
      vecs[7] = '{1'b0, 32'h0000_00A0, 1'b0, 32'h0000_00B0, 0};

      clear_inputs();
      i_rst = 1;
      repeat (2) @(negedge i_clk);
      chk("rst_sel", 64'(bus.mas_sel), 64'd0);
      chk("rst_arvalid", 64'(bus.s_ARVALID), 64'd0);
      chk("rst_rready", 64'(bus.s_RREADY), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_araddr", 64'(bus.s_ARADDR), 64'd0);
      i_rst = 0;

      // First burst: m1, ARID=1, ARLEN=3, four beats
      drive_req(1, 32'h0000_0010, 8'd3, 0, 32'h0, 8'd0);
      id_m[1] = 64'd1; bus.m1_ARID = 64'd1;
      @(negedge i_clk);
      check_grant(1, "first");
      do_burst(1, 4, 0, 0);
      last_win = 1;

      for (int i = 0; i < 8; i++) begin
         drive_req(vecs[i].v1, vecs[i].a1, 8'd0, vecs[i].v2, vecs[i].a2, 8'd0);
         @(negedge i_clk);
         check_grant(vecs[i].exp_sel, $sformatf("vec%0d", i));
         if (vecs[i].exp_sel != 0) begin
            last_win = vecs[i].exp_sel;
            do_burst(vecs[i].exp_sel, 1, 0, 0);
         end else begin
            bus.m1_ARVALID = 0; bus.m2_ARVALID = 0;
            @(negedge i_clk);
            chk($sformatf("vec%0d_idle", i), 64'(bus.busy), 64'd0);
         end
      end

      // ARVALID withdrawn in ADDR, then R stalled by the master's RREADY
      drive_req(1, 32'h0000_0300, 8'd0, 0, 32'h0, 8'd0);
      @(negedge i_clk);
      check_grant(1, "stall");
      bus.m1_ARVALID = 0;
      #1 chk("drop_arvalid", 64'(bus.s_ARVALID), 64'd0);
      @(negedge i_clk);
      chk("drop_sel", 64'(bus.mas_sel), 64'd1);
      chk("drop_busy", 64'(bus.busy), 64'd1);
      bus.m1_ARVALID = 1;
      #1 chk("reassert_arvalid", 64'(bus.s_ARVALID), 64'd1);
      bus.s_ARREADY = 1;
      @(negedge i_clk);
      bus.s_ARREADY = 0; bus.m1_ARVALID = 0;
      bus.s_RVALID = 1; bus.s_RLAST = 1; bus.m1_RREADY = 0; bus.m2_RREADY = 1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("stall_rready", 64'(bus.s_RREADY), 64'd0);
         @(negedge i_clk);
         chk("stall_sel", 64'(bus.mas_sel), 64'd1);
      end
      bus.m1_RREADY = 1;
      #1 chk("stall_go", 64'(bus.s_RREADY), 64'd1);
      @(negedge i_clk);
      bus.s_RVALID = 0; bus.s_RLAST = 0; bus.m1_RREADY = 0; bus.m2_RREADY = 0;
      chk("stall_release", 64'(bus.mas_sel), 64'd0);
      last_win = 1;

      for (int t = 0; t < 150; t++) begin
         v1 = ($urandom_range(0, 3) != 0);
         v2 = ($urandom_range(0, 3) != 0);
         a1 = ($urandom_range(0, 4) != 0) ? {4'h0, 28'($urandom)} : {4'($urandom_range(1, 15)), 28'($urandom)};
         a2 = ($urandom_range(0, 4) != 0) ? {4'h0, 28'($urandom)} : {4'($urandom_range(1, 15)), 28'($urandom)};
         exp = model_grant(v1, a1, v2, a2);
         drive_req(v1, a1, 8'($urandom_range(0, 3)), v2, a2, 8'($urandom_range(0, 3)));
         @(negedge i_clk);
         check_grant(exp, "rnd");
         if (exp != 0) begin
            last_win = exp;
            do_burst(exp, int'(len_m[exp]) + 1, $urandom_range(0, 2), 1);
         end else begin
            bus.m1_ARVALID = 0; bus.m2_ARVALID = 0;
            @(negedge i_clk);
         end
      end

      // Asynchronous reset in the middle of a data phase
      drive_req(1, 32'h0000_0400, 8'd3, 0, 32'h0, 8'd0);
      @(negedge i_clk);
      check_grant(1, "midrst");
      bus.s_ARREADY = 1;
      @(negedge i_clk);
      bus.s_ARREADY = 0; bus.m1_ARVALID = 0;
      bus.s_RVALID = 1; bus.m1_RREADY = 1;
      #1 chk("midrst_pre_rready", 64'(bus.s_RREADY), 64'd1);
      #1 i_rst = 1;
      #1;
      chk("midrst_sel", 64'(bus.mas_sel), 64'd0);
      chk("midrst_busy", 64'(bus.busy), 64'd0);
      chk("midrst_rready", 64'(bus.s_RREADY), 64'd0);
      chk("midrst_araddr", 64'(bus.s_ARADDR), 64'd0);
      @(negedge i_clk);
      clear_inputs();
      i_rst = 0;
      last_win = 2;

      // Tie after reset: m1 first, m2 only after an IDLE gap
      drive_req(1, 32'h0000_0100, 8'd0, 1, 32'h0000_0200, 8'd0);
      @(negedge i_clk);
      check_grant(1, "tie1");
      bus.s_ARREADY = 1;
      @(negedge i_clk);
      bus.s_ARREADY = 0; bus.m1_ARVALID = 0;
      bus.s_RVALID = 1; bus.s_RLAST = 1; bus.m1_RREADY = 1;
      @(negedge i_clk);
      bus.s_RVALID = 0; bus.s_RLAST = 0; bus.m1_RREADY = 0;
      chk("gap_sel", 64'(bus.mas_sel), 64'd0);
      chk("gap_arvalid", 64'(bus.s_ARVALID), 64'd0);
      chk("gap_busy", 64'(bus.busy), 64'd0);
      @(negedge i_clk);
      check_grant(2, "tie2");
      do_burst(2, 1, 0, 0);

`ifdef RD_ARB_BEAT_CHECK_EN
      drive_req(1, 32'h0000_0500, 8'd1, 0, 32'h0, 8'd0);
      @(negedge i_clk);
      check_grant(1, "bchk");
      bus.s_ARREADY = 1;
      @(negedge i_clk);
      bus.s_ARREADY = 0; bus.m1_ARVALID = 0;
      bus.s_RVALID = 1; bus.s_RLAST = 0; bus.m1_RREADY = 1;
      @(negedge i_clk);
      chk("bchk_beat1_sel", 64'(bus.mas_sel), 64'd1);
      chk("bchk_beat1_err", 64'(beat_err), 64'd0);
      @(negedge i_clk);
      bus.s_RVALID = 0; bus.m1_RREADY = 0;
      chk("bchk_release", 64'(bus.mas_sel), 64'd0);
      chk("bchk_err", 64'(beat_err), 64'd1);
      @(negedge i_clk);
      chk("bchk_err_pulse", 64'(beat_err), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
